// File: rtl/jesd204_tx_ilas_pkg.sv
// Shared constants and state encoding for the JESD204B TX ILAS generator.
package jesd204_tx_ilas_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;

  localparam logic [7:0] MIN_BEATS_PER_MF = 8'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ILAS,
    DONE
  } state_t;

endpackage

// File: rtl/jesd204_tx_ilas_beat_fmt.sv
// Combinational ILAS beat formatter: maps (multiframe, beat, last beat, config word)
// to the 4-octet lane word and its per-byte K flags.
module jesd204_tx_ilas_beat_fmt
  import jesd204_tx_ilas_pkg::*;
(
  input  logic [7:0]  mf,
  input  logic [7:0]  beat,
  input  logic [7:0]  beats_per_mf,
  input  logic [31:0] cfg_word,
  output logic [31:0] data,
  output logic [3:0]  charisk
);

  always_comb begin
    charisk = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      data[8*i +: 8] = 8'({beat, 2'b00} + 10'(i));
    end
    // Multiframe 1 carries the four link config words in its first beats
    if (mf == 8'd1 && beat < 8'd4) begin
      data = cfg_word;
    end
    if (beat == 8'd0) begin
      data[7:0]  = K28_0;
      charisk[0] = 1'b1;
      if (mf == 8'd1) begin
        data[15:8] = K28_4;
        charisk[1] = 1'b1;
      end
    end
    if (beat == beats_per_mf) begin
      data[31:24] = K28_3;
      charisk[3]  = 1'b1;
    end
  end

endmodule

// File: rtl/jesd204_tx_ilas_gen.sv
// Per-lane JESD204B TX ILAS generator: FSM, beat/MF counters, config read lookahead.
// Optional JESD204_TX_ILAS_CONTINUOUS_EN adds cfg_ilas_continuous for repeating ILAS.
module jesd204_tx_ilas_gen
  import jesd204_tx_ilas_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic        core_clk,
  input  logic        core_reset,
`ifdef JESD204_TX_ILAS_CONTINUOUS_EN
  input  logic        cfg_ilas_continuous,
`endif
  input  logic [7:0]  cfg_beats_per_multiframe,
  input  logic [7:0]  cfg_ilas_multiframes,
  input  logic        ilas_req,
  input  logic        lmfc_edge,
  output logic        ilas_config_rd,
  output logic [1:0]  ilas_config_addr,
  input  logic [31:0] ilas_config_data,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_charisk,
  output logic        ilas_active,
  output logic        ilas_done,
  output logic        ilas_cfg_err
);

  if (DATA_PATH_WIDTH != 4) begin : g_bad_width
    $error("jesd204_tx_ilas_gen supports only DATA_PATH_WIDTH = 4");
  end

  localparam logic [31:0] IDLE_DATA = {4{K28_5}};

  logic cont_en;
`ifdef JESD204_TX_ILAS_CONTINUOUS_EN
  assign cont_en = cfg_ilas_continuous;
`else
  assign cont_en = 1'b0;
`endif

  state_t      state;
  logic [7:0]  mf_cnt, beat_cnt, bpm, last_mf;
  logic [7:0]  nxt_mf, nxt_beat, fmt_bpm;
  logic        last_beat;
  logic        rd_nxt;
  logic [1:0]  addr_nxt;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_charisk;

  // Next beat to load; in WAIT the config is not latched yet, so use the live inputs
  always_comb begin
    fmt_bpm   = (state == WAIT) ? cfg_beats_per_multiframe : bpm;
    nxt_mf    = 8'd0;
    nxt_beat  = 8'd0;
    last_beat = 1'b0;
    if (state == ILAS) begin
      last_beat = (beat_cnt == bpm) && (mf_cnt == last_mf);
      if (beat_cnt == bpm) begin
        nxt_beat = 8'd0;
        nxt_mf   = last_beat ? 8'd0 : 8'(mf_cnt + 8'd1);
      end else begin
        nxt_beat = 8'(beat_cnt + 8'd1);
        nxt_mf   = mf_cnt;
      end
    end
  end

  // Reads run one beat ahead so each word arrives in the cycle its beat is formatted
  always_comb begin
    rd_nxt   = 1'b1;
    addr_nxt = 2'd0;
    if (nxt_mf == 8'd0 && nxt_beat == 8'(fmt_bpm - 8'd1)) begin
      addr_nxt = 2'd0;
    end else if (nxt_mf == 8'd0 && nxt_beat == fmt_bpm) begin
      addr_nxt = 2'd1;
    end else if (nxt_mf == 8'd1 && nxt_beat == 8'd0) begin
      addr_nxt = 2'd2;
    end else if (nxt_mf == 8'd1 && nxt_beat == 8'd1) begin
      addr_nxt = 2'd3;
    end else begin
      rd_nxt = 1'b0;
    end
  end

  jesd204_tx_ilas_beat_fmt u_beat_fmt (
    .mf           (nxt_mf),
    .beat         (nxt_beat),
    .beats_per_mf (fmt_bpm),
    .cfg_word     (ilas_config_data),
    .data         (fmt_data),
    .charisk      (fmt_charisk)
  );

  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      state            <= IDLE;
      tx_data          <= IDLE_DATA;
      tx_charisk       <= 4'hF;
      ilas_active      <= 1'b0;
      ilas_done        <= 1'b0;
      ilas_config_rd   <= 1'b0;
      ilas_config_addr <= 2'd0;
      ilas_cfg_err     <= 1'b0;
      mf_cnt           <= 8'd0;
      beat_cnt         <= 8'd0;
      bpm              <= 8'd0;
      last_mf          <= 8'd0;
    end else begin
      ilas_done      <= 1'b0;
      ilas_config_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (ilas_req) state <= WAIT;
        end
        WAIT: begin
          if (!ilas_req) begin
            state <= IDLE;
          end else if (lmfc_edge) begin
            bpm     <= cfg_beats_per_multiframe;
            last_mf <= cfg_ilas_multiframes;
            if (cfg_beats_per_multiframe < MIN_BEATS_PER_MF) begin
              ilas_cfg_err <= 1'b1;
              ilas_done    <= 1'b1;
              state        <= DONE;
            end else begin
              state            <= ILAS;
              tx_data          <= fmt_data;
              tx_charisk       <= fmt_charisk;
              ilas_active      <= 1'b1;
              mf_cnt           <= nxt_mf;
              beat_cnt         <= nxt_beat;
              ilas_config_rd   <= rd_nxt;
              ilas_config_addr <= addr_nxt;
            end
          end
        end
        ILAS: begin
          if (!ilas_req || (last_beat && !cont_en)) begin
            state       <= ilas_req ? DONE : IDLE;
            ilas_done   <= ilas_req;
            tx_data     <= IDLE_DATA;
            tx_charisk  <= 4'hF;
            ilas_active <= 1'b0;
          end else begin
            tx_data          <= fmt_data;
            tx_charisk       <= fmt_charisk;
            mf_cnt           <= nxt_mf;
            beat_cnt         <= nxt_beat;
            ilas_config_rd   <= rd_nxt;
            ilas_config_addr <= addr_nxt;
          end
        end
        DONE: begin
          if (!ilas_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
